// File: rtl/writeback_buffer_if.sv
// Bus bundle for the write-back buffer: eviction input, memory drain output,
// and the cache line-fill request/response pair.
interface writeback_buffer_if;
    logic         wb_valid;
    logic         wb_ready;
    logic [31:0]  wb_addr;
    logic [511:0] wb_data;

    logic         mem_wr_valid;
    logic         mem_wr_ready;
    logic [31:0]  mem_wr_addr;
    logic [511:0] mem_wr_data;

    logic         fill_req;
    logic [31:0]  fill_addr;
    logic         fill_busy;
    logic         fill_done;
    logic         fill_hit;
    logic [511:0] fill_data;

    // Cache/memory side of the bundle.
    modport master (
        output wb_valid, wb_addr, wb_data, mem_wr_ready, fill_req, fill_addr,
        input  wb_ready, mem_wr_valid, mem_wr_addr, mem_wr_data,
               fill_busy, fill_done, fill_hit, fill_data
    );

    modport slave (
        input  wb_valid, wb_addr, wb_data, mem_wr_ready, fill_req, fill_addr,
        output wb_ready, mem_wr_valid, mem_wr_addr, mem_wr_data,
               fill_busy, fill_done, fill_hit, fill_data
    );
endinterface

// File: rtl/writeback_buffer.sv
// Write-back buffer: FIFO of evicted dirty lines draining to memory, plus a line-fill FSM.
// Define WB_FORWARD_EN to let fills be served from buffered lines instead of waiting for the drain.
module writeback_buffer #(
    parameter int DEPTH     = 4,
    parameter int MEM_DELAY = 20
) (
    input  logic               clk,
    input  logic               rst_n,
    writeback_buffer_if.slave  bus,
    output logic [2:0]         count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int DLY_W = 5;

    typedef enum logic [1:0] {
        F_IDLE,
        F_LOOKUP,
        F_WAIT,
        F_DONE
    } fill_state_e;

    logic [25:0]      line_addr_q [DEPTH];
    logic [25:0]      line_addr_d [DEPTH];
    logic [511:0]     line_data_q [DEPTH];
    logic [511:0]     line_data_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             wb_ready_q, wb_ready_d;
    logic             enq, deq;

    fill_state_e      state_q, state_d;
    logic [25:0]      fill_line_q, fill_line_d;
    logic [DLY_W-1:0] delay_cnt_q, delay_cnt_d;
    logic [511:0]     fill_data_q, fill_data_d;
    logic [511:0]     miss_data;
    logic             wait_done;

    logic             unused_addr_bits;
    assign unused_addr_bits = ^{bus.wb_addr[5:0], bus.fill_addr[5:0]};

    // FIFO bookkeeping; wb_ready is registered so a full buffer never accepts
    // a line even when the head drains on the same edge.
    always_comb begin
        enq        = bus.wb_valid && wb_ready_q;
        deq        = (count_q != '0) && bus.mem_wr_ready;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        if (enq) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (deq) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({enq, deq})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        wb_ready_d = (count_d != CNT_W'(DEPTH));
    end

    always_comb begin
        line_addr_d = line_addr_q;
        line_data_d = line_data_q;
        if (enq) begin
            line_addr_d[wr_ptr_q] = bus.wb_addr[31:6];
            line_data_d[wr_ptr_q] = bus.wb_data;
        end
    end

    always_ff @(posedge clk) begin
        line_addr_q <= line_addr_d;
        line_data_q <= line_data_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            wb_ready_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            wb_ready_q <= wb_ready_d;
        end
    end

`ifdef WB_FORWARD_EN
    logic [DEPTH-1:0] valid_q, valid_d;
    logic             fwd_match;
    logic [PTR_W-1:0] fwd_idx;
    logic [PTR_W-1:0] scan_idx;
    logic             fill_hit_q, fill_hit_d;

    always_comb begin
        valid_d = valid_q;
        if (deq) begin
            valid_d[rd_ptr_q] = 1'b0;
        end
        if (enq) begin
            valid_d[wr_ptr_q] = 1'b1;
        end
    end

    // Scan oldest to youngest so the last match, the youngest copy, wins.
    always_comb begin
        fwd_match = 1'b0;
        fwd_idx   = rd_ptr_q;
        scan_idx  = rd_ptr_q;
        for (int i = 0; i < DEPTH; i++) begin
            scan_idx = rd_ptr_q + PTR_W'(i);
            if (valid_q[scan_idx] && (line_addr_q[scan_idx] == fill_line_q)) begin
                fwd_match = 1'b1;
                fwd_idx   = scan_idx;
            end
        end
    end

    always_comb begin
        fill_hit_d = fill_hit_q;
        if ((state_q == F_LOOKUP) && fwd_match) begin
            fill_hit_d = 1'b1;
        end else if (wait_done) begin
            fill_hit_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q    <= '0;
            fill_hit_q <= 1'b0;
        end else begin
            valid_q    <= valid_d;
            fill_hit_q <= fill_hit_d;
        end
    end

    assign bus.fill_hit = fill_hit_q;
`else
    assign bus.fill_hit = 1'b0;
`endif

    // Memory fill response: word k carries the line address plus 4k.
    always_comb begin
        miss_data = '0;
        for (int k = 0; k < 16; k++) begin
            miss_data[32*k +: 32] = {fill_line_q, 6'(4 * k)};
        end
    end

    assign wait_done = (state_q == F_WAIT) && (delay_cnt_q == DLY_W'(MEM_DELAY - 1));

    always_comb begin
        state_d     = state_q;
        fill_line_d = fill_line_q;
        delay_cnt_d = delay_cnt_q;
        fill_data_d = fill_data_q;
        case (state_q)
            F_IDLE: begin
                if (bus.fill_req) begin
                    fill_line_d = bus.fill_addr[31:6];
                    state_d     = F_LOOKUP;
                end
            end
            F_LOOKUP: begin
`ifdef WB_FORWARD_EN
                if (fwd_match) begin
                    fill_data_d = line_data_q[fwd_idx];
                    state_d     = F_DONE;
                end else begin
                    delay_cnt_d = '0;
                    state_d     = F_WAIT;
                end
`else
                // Hold until every pending write-back has drained.
                if (count_q == '0) begin
                    delay_cnt_d = '0;
                    state_d     = F_WAIT;
                end
`endif
            end
            F_WAIT: begin
                if (wait_done) begin
                    fill_data_d = miss_data;
                    state_d     = F_DONE;
                end else begin
                    delay_cnt_d = delay_cnt_q + 1'b1;
                end
            end
            F_DONE: begin
                state_d = F_IDLE;
            end
            default: begin
                state_d = F_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= F_IDLE;
            fill_line_q <= '0;
            delay_cnt_q <= '0;
            fill_data_q <= '0;
        end else begin
            state_q     <= state_d;
            fill_line_q <= fill_line_d;
            delay_cnt_q <= delay_cnt_d;
            fill_data_q <= fill_data_d;
        end
    end

    assign bus.wb_ready     = wb_ready_q;
    assign bus.mem_wr_valid = (count_q != '0);
    assign bus.mem_wr_addr  = {line_addr_q[rd_ptr_q], 6'b0};
    assign bus.mem_wr_data  = line_data_q[rd_ptr_q];
    assign bus.fill_busy    = (state_q != F_IDLE);
    assign bus.fill_done    = (state_q == F_DONE);
    assign bus.fill_data    = fill_data_q;
    // A full DEPTH=8 buffer wraps to 0 on this 3-bit port.
    assign count            = 3'(count_q);
endmodule
